// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI pad arbiter: FSM state encoding,
// owner encoding and the values the pads are parked at when nobody owns them.
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_RAM = 2'd1,
        OWN_NOR = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_RAM = 1'b0,
        OWNER_NOR = 1'b1
    } owner_t;

    localparam logic       SAFE_CE_N   = 1'b1;
    localparam logic       SAFE_SCLK   = 1'b0;
    localparam logic [3:0] SAFE_SIO_O  = 4'h0;
    localparam logic [3:0] SAFE_SIO_OE = 4'h0;

endpackage

// File: rtl/qspi_pad_mux.sv
// Combinational owner-to-pad selector. Only the client named by the registered
// arbiter state reaches the pads; everything else sees the parked values.
module qspi_pad_mux
    import qspi_arb_pkg::*;
(
    input  arb_state_t state,
    input  logic       ram_ce_n,
    input  logic       ram_sclk,
    input  logic [3:0] ram_sio_o,
    input  logic [3:0] ram_sio_oe,
    input  logic       nor_ce_n,
    input  logic       nor_sclk,
    input  logic [3:0] nor_sio_o,
    input  logic [3:0] nor_sio_oe,
    output logic       ce0,
    output logic       ce1,
    output logic       sclk_ram,
    output logic       sclk_nor,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe
);

    // Park all pads, then pass through the owning client only.
    always_comb begin
        ce0      = SAFE_CE_N;
        ce1      = SAFE_CE_N;
        sclk_ram = SAFE_SCLK;
        sclk_nor = SAFE_SCLK;
        sio_o    = SAFE_SIO_O;
        sio_oe   = SAFE_SIO_OE;
        case (state)
            OWN_RAM: begin
                ce0      = ram_ce_n;
                sclk_ram = ram_sclk;
                sio_o    = ram_sio_o;
                sio_oe   = ram_sio_oe;
            end
            OWN_NOR: begin
                ce1      = nor_ce_n;
                sclk_nor = nor_sclk;
                sio_o    = nor_sio_o;
                sio_oe   = nor_sio_oe;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Arbiter sharing one QSPI pad group between the PSRAM and NOR controllers.
// Grants per transaction, alternates on ties, inserts a TURN_CYCLES gap of
// parked pads between owners. Define QSPI_ARB_TIMEOUT_EN to revoke a grant
// held for MAX_HOLD cycles while the other client waits (sets err_timeout).
//
// state   | meaning
// IDLE    | bus parked, arbitrating pending requests
// OWN_RAM | PSRAM client drives pads, ce0 live
// OWN_NOR | NOR client drives pads, ce1 live
// TURN    | bus parked for TURN_CYCLES after a release or revoke
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ram_req,
    output logic       ram_gnt,
    input  logic       ram_ce_n,
    input  logic       ram_sclk,
    input  logic [3:0] ram_sio_o,
    input  logic [3:0] ram_sio_oe,
    output logic [3:0] ram_sio_i,
    input  logic       nor_req,
    output logic       nor_gnt,
    input  logic       nor_ce_n,
    input  logic       nor_sclk,
    input  logic [3:0] nor_sio_o,
    input  logic [3:0] nor_sio_oe,
    output logic [3:0] nor_sio_i,
    input  logic [3:0] sio_i,
    output logic       ce0,
    output logic       ce1,
    output logic       sclk_ram,
    output logic       sclk_nor,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe,
    output logic       err_timeout
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("qspi_bus_arbiter: TURN_CYCLES must be 1..15");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("qspi_bus_arbiter: MAX_HOLD must be >= 1");
    end

    // TURN counts down from TURN_CYCLES-1 so it lasts exactly TURN_CYCLES cycles.
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    arb_state_t state, state_nxt;
    owner_t     last_owner, last_owner_nxt;
    logic [3:0] turn_cnt, turn_cnt_nxt;
    logic       timeout_hit;

    // State, tie-break history and turnaround timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWNER_NOR;
            turn_cnt   <= 4'd0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            turn_cnt   <= turn_cnt_nxt;
        end
    end

    // Next-state: arbitration in IDLE, release/revoke in OWN, timed gap in TURN.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        turn_cnt_nxt   = turn_cnt;
        case (state)
            IDLE: begin
                if (ram_req && (!nor_req || last_owner == OWNER_NOR))
                    state_nxt = OWN_RAM;
                else if (nor_req)
                    state_nxt = OWN_NOR;
            end
            OWN_RAM: begin
                if (!ram_req || timeout_hit) begin
                    state_nxt      = TURN;
                    last_owner_nxt = OWNER_RAM;
                    turn_cnt_nxt   = TURN_LOAD;
                end
            end
            OWN_NOR: begin
                if (!nor_req || timeout_hit) begin
                    state_nxt      = TURN;
                    last_owner_nxt = OWNER_NOR;
                    turn_cnt_nxt   = TURN_LOAD;
                end
            end
            TURN: begin
                if (turn_cnt == 4'd0)
                    state_nxt = IDLE;
                else
                    turn_cnt_nxt = turn_cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              err_q;
    logic              owning;
    logic              other_waiting;

    assign owning        = (state == OWN_RAM) || (state == OWN_NOR);
    assign other_waiting = ((state == OWN_RAM) && nor_req) || ((state == OWN_NOR) && ram_req);
    assign timeout_hit   = owning && (hold_cnt == HOLD_W'(MAX_HOLD));
    assign err_timeout   = err_q;

    // Hold counter restarts outside ownership; counts only while the other side waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!owning)
                hold_cnt <= '0;
            else if (other_waiting && !timeout_hit)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign ram_gnt   = (state == OWN_RAM);
    assign nor_gnt   = (state == OWN_NOR);
    assign ram_sio_i = sio_i;
    assign nor_sio_i = sio_i;

    qspi_pad_mux u_pad_mux (
        .state      (state),
        .ram_ce_n   (ram_ce_n),
        .ram_sclk   (ram_sclk),
        .ram_sio_o  (ram_sio_o),
        .ram_sio_oe (ram_sio_oe),
        .nor_ce_n   (nor_ce_n),
        .nor_sclk   (nor_sclk),
        .nor_sio_o  (nor_sio_o),
        .nor_sio_oe (nor_sio_oe),
        .ce0        (ce0),
        .ce1        (ce1),
        .sclk_ram   (sclk_ram),
        .sclk_nor   (sclk_nor),
        .sio_o      (sio_o),
        .sio_oe     (sio_oe)
    );

endmodule

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
- Shares the single QSPI pad group (sio0..sio3 data/OE) between two clients: the PSRAM controller (chip-select ce0, sclk_ram) and the NOR flash controller (ce1, sclk_nor).
- Sits in soc between both memory controllers and the top-level pad mapping.
- Grants exclusive pad ownership per transaction, inserts a bus turnaround gap between owners, and parks the bus safely when idle.

Parameters:
- TURN_CYCLES, 2, idle cycles (all OE low, both CE high) between release and next grant; legal 1..15.
- MAX_HOLD, 1024, cycle limit on a grant while the other client waits (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ram_req  in  1  PSRAM client requests bus; held for whole transaction
- ram_gnt  out  1  PSRAM client owns bus
- ram_ce_n  in  1  PSRAM client chip select
- ram_sclk  in  1  PSRAM client serial clock
- ram_sio_o  in  4  PSRAM client data out
- ram_sio_oe  in  4  PSRAM client output enables
- nor_req, nor_gnt, nor_ce_n, nor_sclk, nor_sio_o, nor_sio_oe: same as ram_*, for the NOR client
- sio_i  in  4  pad data in; fanned out unmodified to both clients
- ce0  out  1  PSRAM pad chip select, active low
- ce1  out  1  NOR pad chip select, active low
- sclk_ram  out  1  PSRAM pad clock
- sclk_nor  out  1  NOR pad clock
- sio_o  out  4  shared pad data out
- sio_oe  out  4  shared pad output enables
- err_timeout  out  1  sticky hold-timeout flag

Behaviour:
- Reset and safe bus values:
  - rst is synchronous, active-high.
  - On reset: state=IDLE, ram_gnt=nor_gnt=0, last_owner=NOR (so PSRAM wins first tie), turnaround counter=0, err_timeout=0.
  - While not owned, pads are driven to ce0=ce1=1, sclk_ram=sclk_nor=0, sio_o=0, sio_oe=0.
- States: IDLE, OWN_RAM, OWN_NOR, TURN.
- IDLE:
  - Only ram_req -> OWN_RAM.
  - Only nor_req -> OWN_NOR.
  - Both requests -> the client that is not last_owner.
  - The matching gnt is asserted from the cycle after req is first sampled, so latency is 1 cycle.
- OWN_x:
  - Pads are a combinational mux from client x, selected by the registered state: ce0 (or ce1) = x_ce_n, x's sclk to its pad, sio_o/sio_oe from x.
  - The non-owner's pad CE is forced 1 and its sclk forced 0.
  - Non-owner ce/sclk/sio inputs are ignored.
- Release:
  - x_req low while in OWN_x -> gnt drops the next cycle, last_owner=x, go to TURN.
  - Clients must drive ce_n high before dropping req. If ce_n is still low at release, the arbiter forces it high anyway.
- TURN:
  - Safe values are driven for exactly TURN_CYCLES cycles, then the state goes to IDLE.
  - A request pending during TURN is granted from IDLE with normal arbitration. Minimum req-to-gnt latency after a release is therefore TURN_CYCLES+1.
- Withdrawals and mid-operation events:
  - A request withdrawn before it is granted produces no grant.
  - Re-asserting req in the same cycle gnt drops is treated as a new request.
  - Both gnt outputs are never 1 in the same cycle.
  - Reset mid-transaction: safe values from the next edge and gnt=0. The interrupted client must observe gnt low and abort.

Optional Feature:
- Macro: QSPI_ARB_TIMEOUT_EN.
- Enabled:
  - A hold counter clears on each grant and increments each OWN cycle while the other req is high.
  - At count==MAX_HOLD the grant is revoked: gnt=0 next cycle, go to TURN, err_timeout set sticky until rst.
  - Purpose: bounds PSRAM tCEM starvation.
- Disabled: no counter; err_timeout tied 0; grants are held indefinitely.

Decomposition:
- Shared package qspi_arb_pkg: state enum (IDLE/OWN_RAM/OWN_NOR/TURN), owner encoding (OWNER_RAM=0, OWNER_NOR=1), pad safe-value constants.
- One sub-module, qspi_pad_mux: combinational owner->pad selector. The FSM, counters and optional timeout stay in the top.

Test Plan:
- Reset then ram_req=1 at cycle 0 -> ram_gnt=1 at cycle 1; ce0 follows ram_ce_n; ce1=1, sclk_nor=0 throughout.
- ram_req and nor_req both rise in the same cycle after reset -> RAM granted first; RAM releases -> TURN_CYCLES=2 cycles with sio_oe=0 and ce0=ce1=1 -> nor_gnt=1 on the third cycle after release.
- Back-to-back with both requests held: alternating grants RAM, NOR, RAM, and nor_sio_oe=4'hF never appears on sio_oe during an OWN_RAM state.
- NOR owns the bus and rst pulses for 1 cycle mid-transfer -> next cycle nor_gnt=0, ce1=1, sio_oe=0, state IDLE.
- QSPI_ARB_TIMEOUT_EN with MAX_HOLD=16: RAM holds, NOR requests -> ram_gnt drops after 16 waiting cycles, err_timeout=1 and stays 1, nor_gnt=1 after turnaround.
- Feature off, same stimulus -> RAM keeps the grant for 100+ cycles, err_timeout=0.
